// File: rtl/linebuf_ctrl_if.sv
// rtl/linebuf_ctrl_if.sv - line-buffer controller writer/scanout/RAM signal bundle
interface linebuf_ctrl_if #(
  parameter int dWidth = 8,
  parameter int aWidth = 10
);
  logic                line_start;
  logic                wr_en;
  logic [aWidth-2:0]   wr_x;
  logic [dWidth-1:0]   wr_data;
  logic                rd_en;
  logic [dWidth-1:0]   pix_data;
  logic                pix_valid;
  logic                line_done;
  logic                err_overrun;
  logic [aWidth-1:0]   ram_addr_a;
  logic                ram_we_a;
  logic [dWidth-1:0]   ram_d_a;
  logic [aWidth-1:0]   ram_addr_b;
  logic                ram_we_b;
  logic [dWidth-1:0]   ram_d_b;
  logic [dWidth-1:0]   ram_q_b;

  modport slave (
    input  line_start, wr_en, wr_x, wr_data, rd_en, ram_q_b,
    output pix_data, pix_valid, line_done, err_overrun,
    output ram_addr_a, ram_we_a, ram_d_a, ram_addr_b, ram_we_b, ram_d_b
  );

  modport master (
    output line_start, wr_en, wr_x, wr_data, rd_en, ram_q_b,
    input  pix_data, pix_valid, line_done, err_overrun,
    input  ram_addr_a, ram_we_a, ram_d_a, ram_addr_b, ram_we_b, ram_d_b
  );
endinterface

// File: rtl/linebuf_ctrl.sv
// rtl/linebuf_ctrl.sv - ping-pong line-buffer controller with clear-after-read scanout
module linebuf_ctrl #(
  parameter int                dWidth    = 8,
  parameter int                aWidth    = 10,
  parameter int                LINE_LEN  = 256,
  parameter logic [dWidth-1:0] CLEAR_VAL = '0
) (
  input  logic           clk,
  input  logic           reset,
  linebuf_ctrl_if.slave  bus
);
  localparam int             XW         = aWidth - 1;
  localparam logic [XW:0]    C_LINE_LEN = (XW+1)'(LINE_LEN);
  localparam logic [XW:0]    C_ONE      = (XW+1)'(1);

  typedef enum logic [1:0] {IDLE, SCAN, CLR, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_bank, w_bank_nxt;
  logic [XW:0]         r_x, w_x_nxt;
  logic [dWidth-1:0]   r_pix_data, w_pix_data_nxt;
  logic                r_pix_valid, w_pix_valid_nxt;
  logic                r_line_done, w_line_done_nxt;
  logic                r_err, w_err_nxt;
  logic                w_we_b;
  logic [XW:0]         w_x_inc;

  assign w_x_inc = r_x + C_ONE;

  // Writer always targets the back bank; out-of-line pixels are dropped.
  assign bus.ram_addr_a = {~r_bank, bus.wr_x};
  assign bus.ram_d_a    = bus.wr_data;
  assign bus.ram_we_a   = bus.wr_en && ({1'b0, bus.wr_x} < C_LINE_LEN);

  assign bus.ram_addr_b = {r_bank, r_x[XW-1:0]};
  assign bus.ram_d_b    = CLEAR_VAL;
  assign bus.ram_we_b   = w_we_b;

  assign bus.pix_data    = r_pix_data;
  assign bus.pix_valid   = r_pix_valid;
  assign bus.line_done   = r_line_done;
  assign bus.err_overrun = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bank      <= 1'b0;
      r_x         <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_line_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bank      <= w_bank_nxt;
      r_x         <= w_x_nxt;
      r_pix_data  <= w_pix_data_nxt;
      r_pix_valid <= w_pix_valid_nxt;
      r_line_done <= w_line_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bank_nxt      = r_bank;
    w_x_nxt         = r_x;
    w_pix_data_nxt  = r_pix_data;
    w_pix_valid_nxt = 1'b0;
    w_line_done_nxt = r_line_done;
    w_err_nxt       = r_err;
    w_we_b          = 1'b0;

    case (r_state)
      SCAN: begin
        if (bus.rd_en && (r_x < C_LINE_LEN)) begin
          w_state_nxt = CLR;
        end
      end
      CLR: begin
        // ram_q_b holds the word read last cycle; write-back clears it now.
        w_we_b          = 1'b1;
        w_pix_data_nxt  = bus.ram_q_b;
        w_pix_valid_nxt = 1'b1;
        w_x_nxt         = w_x_inc;
        if (w_x_inc == C_LINE_LEN) begin
          w_state_nxt     = DONE;
          w_line_done_nxt = 1'b1;
        end else begin
          w_state_nxt = SCAN;
        end
        if (bus.rd_en) begin
          w_err_nxt = 1'b1;
        end
      end
      default: ;
    endcase

    // Line start overrides everything except the in-flight clear and pixel.
    if (bus.line_start) begin
      w_bank_nxt      = ~r_bank;
      w_x_nxt         = '0;
      w_state_nxt     = SCAN;
      w_line_done_nxt = 1'b0;
    end
  end
endmodule

// File: tb/tb_linebuf_ctrl.sv
// tb/tb_linebuf_ctrl.sv - directed self-checking bench for linebuf_ctrl with a dual-port RAM model
module tb_linebuf_ctrl;
  localparam int DW = 8;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: 8'h00};
  logic [DW-1:0] r_q_b = '0;
  logic [DW-1:0] vals [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};

  linebuf_ctrl_if #(.dWidth(DW), .aWidth(AW)) bus ();

  linebuf_ctrl #(.dWidth(DW), .aWidth(AW), .LINE_LEN(256), .CLEAR_VAL(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Dual-port RAM, registered read, write-first on port B.
  always @(posedge clk) begin
    if (bus.ram_we_a) mem[bus.ram_addr_a] <= bus.ram_d_a;
    if (bus.ram_we_b) begin
      mem[bus.ram_addr_b] <= bus.ram_d_b;
      r_q_b               <= bus.ram_d_b;
    end else begin
      r_q_b <= mem[bus.ram_addr_b];
    end
  end
  assign bus.ram_q_b = r_q_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_px(input logic bank, input int x, input logic [7:0] exp, input logic last);
    bus.rd_en = 1'b1;
    #1;
    chk("rd_addr_b", 32'(bus.ram_addr_b), 32'({bank, 9'(x)}));
    chk("rd_we_b", 32'(bus.ram_we_b), 32'd0);
    clk1();
    bus.rd_en = 1'b0;
    #1;
    chk("clr_we_b", 32'(bus.ram_we_b), 32'd1);
    clk1();
    chk("pix_valid", 32'(bus.pix_valid), 32'd1);
    chk("pix_data", 32'(bus.pix_data), 32'(exp));
    chk("line_done", 32'(bus.line_done), 32'(last));
  endtask

  task automatic write_px(input int x, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_x    = 9'(x);
    bus.wr_data = d;
    #1;
    chk("wr_we_a", 32'(bus.ram_we_a), 32'd1);
    clk1();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.line_start = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_x       = '0;
    bus.wr_data    = '0;
    bus.rd_en      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_pix_data", 32'(bus.pix_data), 32'd0);
    chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    chk("rst_line_done", 32'(bus.line_done), 32'd0);
    chk("rst_err", 32'(bus.err_overrun), 32'd0);
    chk("rst_we_a", 32'(bus.ram_we_a), 32'd0);
    chk("rst_we_b", 32'(bus.ram_we_b), 32'd0);

    // IDLE ignores rd_en
    repeat (3) begin
      bus.rd_en = 1'b1;
      clk1();
      bus.rd_en = 1'b0;
      chk("idle_we_b", 32'(bus.ram_we_b), 32'd0);
      clk1();
      chk("idle_pix_valid", 32'(bus.pix_valid), 32'd0);
    end

    // bank -> 1, writer fills bank 0
    bus.line_start = 1'b1;
    clk1();
    bus.line_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_x    = 9'(i);
      bus.wr_data = vals[i];
      #1;
      chk("wr_addr_a", 32'(bus.ram_addr_a), 32'(i));
      chk("wr_we_a", 32'(bus.ram_we_a), 32'd1);
      clk1();
      bus.wr_en = 1'b0;
    end

    // x == LINE_LEN is dropped
    bus.wr_en   = 1'b1;
    bus.wr_x    = 9'd256;
    bus.wr_data = 8'hEE;
    #1;
    chk("oob_we_a", 32'(bus.ram_we_a), 32'd0);
    clk1();
    bus.wr_en = 1'b0;
    chk("oob_mem", 32'(mem[256]), 32'd0);

    // bank -> 0, scan whole line
    bus.line_start = 1'b1;
    clk1();
    bus.line_start = 1'b0;
    for (int x = 0; x < 256; x++) begin
      scan_px(1'b0, x, (x < 4) ? vals[x] : 8'h00, x == 255);
    end
    bus.rd_en = 1'b1;
    clk1();
    bus.rd_en = 1'b0;
    chk("done_we_b", 32'(bus.ram_we_b), 32'd0);
    clk1();
    chk("done_pix_valid", 32'(bus.pix_valid), 32'd0);
    chk("done_line_done", 32'(bus.line_done), 32'd1);
    for (int i = 0; i < 4; i++) chk("cleared_mem", 32'(mem[i]), 32'd0);
    chk("no_err_yet", 32'(bus.err_overrun), 32'd0);

    // bank -> 1, back-to-back rd_en
    bus.line_start = 1'b1;
    clk1();
    bus.line_start = 1'b0;
    chk("ls_line_done", 32'(bus.line_done), 32'd0);
    bus.rd_en = 1'b1;
    clk1();
    #1;
    chk("ovr_we_b", 32'(bus.ram_we_b), 32'd1);
    clk1();
    bus.rd_en = 1'b0;
    chk("ovr_pix_valid", 32'(bus.pix_valid), 32'd1);
    chk("ovr_err", 32'(bus.err_overrun), 32'd1);
    clk1();
    chk("ovr_single_px", 32'(bus.pix_valid), 32'd0);
    chk("ovr_addr_b", 32'(bus.ram_addr_b), 32'(10'h201));

    // preload bank 0 for the mid-scan line_start case
    write_px(10, 8'hA5);
    write_px(11, 8'hB6);
    bus.line_start = 1'b1;
    clk1();
    bus.line_start = 1'b0;
    chk("err_sticky", 32'(bus.err_overrun), 32'd1);
    for (int x = 0; x < 10; x++) scan_px(1'b0, x, 8'h00, 1'b0);

    // line_start lands in the CLR cycle of x=10
    bus.rd_en = 1'b1;
    clk1();
    bus.rd_en      = 1'b0;
    bus.line_start = 1'b1;
    #1;
    chk("mid_we_b", 32'(bus.ram_we_b), 32'd1);
    chk("mid_addr_b", 32'(bus.ram_addr_b), 32'd10);
    clk1();
    bus.line_start = 1'b0;
    chk("mid_pix_valid", 32'(bus.pix_valid), 32'd1);
    chk("mid_pix_data", 32'(bus.pix_data), 32'hA5);
    chk("mid_new_addr_b", 32'(bus.ram_addr_b), 32'(10'h200));
    chk("mid_cleared", 32'(mem[10]), 32'd0);
    chk("mid_stale", 32'(mem[11]), 32'hB6);
    clk1();
    chk("mid_hold_data", 32'(bus.pix_data), 32'hA5);
    chk("mid_valid_drop", 32'(bus.pix_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
